seven_segment_decoder: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 66 ++++++
 rtl/seg_sync.sv | 24 ++
 rtl/seven_segment_decoder.sv | 128 ++++++++++++
 tb/tb_seven_segment_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the segment read-back decoder: segment patterns,
// filter FSM states and the pattern-to-digit decode.
package seven_seg_pkg;

  typedef enum logic {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Segment word is {A,B,C,D,E,F,G}, A in the MSB.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1110011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] value;
  } dec_t;

  // A pattern that is neither a digit nor blank is an error pattern.
  function automatic dec_t seg_decode(input logic [6:0] seg);
    dec_t r;
    r       = '0;
    r.valid = 1'b1;
    case (seg)
      SEG_0:     r.value = 4'h0;
      SEG_1:     r.value = 4'h1;
      SEG_2:     r.value = 4'h2;
      SEG_3:     r.value = 4'h3;
      SEG_4:     r.value = 4'h4;
      SEG_5:     r.value = 4'h5;
      SEG_6:     r.value = 4'h6;
      SEG_7:     r.value = 4'h7;
      SEG_8:     r.value = 4'h8;
      SEG_9:     r.value = 4'h9;
      SEG_A:     r.value = 4'hA;
      SEG_B:     r.value = 4'hB;
      SEG_C:     r.value = 4'hC;
      SEG_D:     r.value = 4'hD;
      SEG_E:     r.value = 4'hE;
      SEG_F:     r.value = 4'hF;
      SEG_BLANK: begin
        r.valid = 1'b0;
        r.blank = 1'b1;
      end
      default:   r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Multi-flop synchronizer for the asynchronous segment lines.
module seg_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], i_data};
    end
  end

  assign o_data = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/seven_segment_decoder.sv
// Reads seven segment lines back into a hex digit: synchronize, require a
// stable pattern for STABLE_CYCLES samples, then decode and flag blank/error.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_seg_A,
  input  logic       i_seg_B,
  input  logic       i_seg_C,
  input  logic       i_seg_D,
  input  logic       i_seg_E,
  input  logic       i_seg_F,
  input  logic       i_seg_G,
  output logic [3:0] o_value,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_error
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0] seg_raw;
  logic [6:0] seg_sync_w;

  assign seg_raw = {i_seg_A, i_seg_B, i_seg_C, i_seg_D, i_seg_E, i_seg_F, i_seg_G};

  seg_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (7)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_data (seg_raw),
    .o_data (seg_sync_w)
  );

  state_e        state_q, state_d;
  logic [6:0]    cand_q,  cand_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          blank_q, blank_d;
  logic          error_q, error_d;
  logic          digit_q, digit_d;   // last accept was a legal digit
  dec_t          dec;

  assign dec = seg_decode(cand_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    blank_d = blank_q;
    error_d = error_q;
    digit_d = digit_q;
    case (state_q)
      TRACK: begin
        if (seg_sync_w != cand_q) begin
          cand_d = seg_sync_w;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOCKED;
          // A repeated digit is suppressed only if the previous accept was that digit.
          if (dec.valid) begin
            valid_d = (dec.value != value_q) || !digit_q;
            value_d = dec.value;
            blank_d = 1'b0;
            error_d = 1'b0;
            digit_d = 1'b1;
          end else if (dec.blank) begin
            blank_d = 1'b1;
            error_d = 1'b0;
            digit_d = 1'b0;
          end else begin
            blank_d = 1'b0;
            error_d = 1'b1;
            digit_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (seg_sync_w != cand_q) begin
          cand_d  = seg_sync_w;
          cnt_d   = '0;
          state_d = TRACK;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= TRACK;
      cand_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
      error_q <= 1'b0;
      digit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      error_q <= error_d;
      digit_q <= digit_d;
    end
  end

  assign o_value = value_q;
  assign o_valid = valid_q;
  assign o_blank = blank_q;
  assign o_error = error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench for seven_segment_decoder: directed scenarios plus
// randomized patterns compared against a run-length reference model.
module tb_seven_segment_decoder;

  localparam int SYNC = 2;
  localparam int STAB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg   = '0;
  logic [3:0] o_value;
  logic       o_valid, o_blank, o_error;

  always #5 clk = ~clk;

  seven_segment_decoder #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STAB)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_seg_A(seg[6]),
    .i_seg_B(seg[5]),
    .i_seg_C(seg[4]),
    .i_seg_D(seg[3]),
    .i_seg_E(seg[2]),
    .i_seg_F(seg[1]),
    .i_seg_G(seg[0]),
    .o_value(o_value),
    .o_valid(o_valid),
    .o_blank(o_blank),
    .o_error(o_error)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: a pattern is accepted once the synchronized value has
  // been the same for STAB+1 consecutive edges (reset counts as one).
  logic [6:0] m_dly [SYNC];
  logic [6:0] m_prev;
  int         m_run;
  logic [3:0] m_value;
  logic       m_valid, m_blank, m_error;
  int         m_kind;   // 0 none, 1 digit, 2 blank/error

  int         nvalid;
  bit         seen3;
  logic [3:0] vq [$];

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_dly[i] = '0;
    m_prev  = '0;
    m_run   = 1;
    m_value = '0;
    m_valid = 1'b0;
    m_blank = 1'b0;
    m_error = 1'b0;
    m_kind  = 0;
  endtask

  task automatic model_edge();
    logic [6:0] s;
    int d;
    s = m_dly[SYNC-1];
    m_valid = 1'b0;
    if (s == m_prev) begin
      if (m_run < STAB + 2) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = s;
    if (m_run == STAB + 1) begin
      d = -1;
      for (int k = 0; k < 16; k++) if (tbl[k] == s) d = k;
      if (d >= 0) begin
        m_valid = (4'(d) != m_value) || (m_kind != 1);
        m_value = 4'(d);
        m_blank = 1'b0;
        m_error = 1'b0;
        m_kind  = 1;
      end else if (s == 7'd0) begin
        m_blank = 1'b1;
        m_error = 1'b0;
        m_kind  = 2;
      end else begin
        m_blank = 1'b0;
        m_error = 1'b1;
        m_kind  = 2;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = seg;
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs only change between calls, after the check.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("value", 7'(o_value), 7'(m_value));
      chk("valid", 7'(o_valid), 7'(m_valid));
      chk("blank", 7'(o_blank), 7'(m_blank));
      chk("error", 7'(o_error), 7'(m_error));
      chk("excl", 7'((o_blank && o_error) || (o_valid && (o_blank || o_error))), 7'd0);
      if (o_valid) begin
        nvalid++;
        vq.push_back(o_value);
      end
      if (o_value == 4'h3) seen3 = 1'b1;
    end
  endtask

  initial begin
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 7'(o_value), 7'd0);
    chk("rst_valid", 7'(o_valid), 7'd0);
    chk("rst_blank", 7'(o_blank), 7'd0);
    chk("rst_error", 7'(o_error), 7'd0);

    // Blank after reset release
    rst_n  = 1'b1;
    nvalid = 0;
    step(7);
    chk("init_blank", 7'(o_blank), 7'd1);
    chk("init_value", 7'(o_value), 7'd0);
    chk("init_nvalid", 7'(nvalid), 7'd0);

    // Digit 2 with seven-edge latency
    seg = tbl[2]; nvalid = 0;
    step(6);
    chk("pre2_value", 7'(o_value), 7'd0);
    chk("pre2_blank", 7'(o_blank), 7'd1);
    step(1);
    chk("acc2_value", 7'(o_value), 7'd2);
    chk("acc2_valid", 7'(o_valid), 7'd1);
    chk("acc2_blank", 7'(o_blank), 7'd0);
    step(3);
    chk("acc2_pulses", 7'(nvalid), 7'd1);

    // Short glitch to 3, then back to 2
    seen3 = 1'b0; nvalid = 0;
    seg = tbl[3];
    step(3);
    seg = tbl[2];
    step(12);
    chk("glitch_seen3", 7'(seen3), 7'd0);
    chk("glitch_pulses", 7'(nvalid), 7'd0);
    chk("glitch_value", 7'(o_value), 7'd2);

    // Illegal pattern, then F
    seg = 7'b1010101; nvalid = 0;
    step(10);
    chk("ill_error", 7'(o_error), 7'd1);
    chk("ill_value", 7'(o_value), 7'd2);
    chk("ill_pulses", 7'(nvalid), 7'd0);
    seg = tbl[15]; nvalid = 0;
    step(10);
    chk("F_error", 7'(o_error), 7'd0);
    chk("F_value", 7'(o_value), 7'hF);
    chk("F_pulses", 7'(nvalid), 7'd1);

    // Sweep all digits
    vq.delete(); nvalid = 0;
    for (int d = 0; d < 16; d++) begin
      seg = tbl[d];
      step(8);
    end
    chk("sweep_pulses", 7'(nvalid), 7'd16);
    for (int i = 0; i < 16; i++)
      chk("sweep_order", (i < vq.size()) ? 7'(vq[i]) : 7'h7F, 7'(i));

    // Randomized patterns and hold times
    repeat (150) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       seg = tbl[$urandom_range(0, 15)];
      else if (r == 6) seg = '0;
      else             seg = 7'($urandom);
      step(int'($urandom_range(1, 10)));
    end

    // Asynchronous reset while tracking a new pattern
    seg = tbl[8];
    step(8);
    seg = tbl[1];
    step(5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_value", 7'(o_value), 7'd0);
    chk("arst_valid", 7'(o_valid), 7'd0);
    chk("arst_blank", 7'(o_blank), 7'd0);
    chk("arst_error", 7'(o_error), 7'd0);
    #3 rst_n = 1'b1;
    nvalid = 0;
    step(6);
    chk("rel_pre_value", 7'(o_value), 7'd0);
    chk("rel_pre_pulses", 7'(nvalid), 7'd0);
    step(1);
    chk("rel_value", 7'(o_value), 7'd1);
    chk("rel_valid", 7'(o_valid), 7'd1);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
